// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives a req/ack imem port, feeds decode via valid/ready with a one-entry skid.
// First instruction 2 cycles after reset with zero-wait memory, then 1/cycle; decode stall parks one response in the skid and drops req.
module fetch_controller #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus_four,
    output logic [XLEN-1:0] if_instruction,
    output logic [31:0]     fetched_count
);
    typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HOLD} state_t;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] held_addr_q, held_addr_d;
    logic            kill_q, kill_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_ppf_q, out_ppf_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [31:0]     count_q, count_d;
    logic            accept;
    logic            slot_free;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req        = (state_q == ST_FETCH);
    assign imem_addr       = kill_q ? held_addr_q : pc_q;
    assign if_valid        = valid_q;
    assign if_pc           = out_pc_q;
    assign if_pc_plus_four = out_ppf_q;
    assign if_instruction  = out_instr_q;
    assign fetched_count   = count_q;

    assign accept    = valid_q & if_ready;
    assign slot_free = ~valid_q | accept;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        held_addr_d  = held_addr_q;
        kill_d       = kill_q;
        valid_d      = valid_q;
        out_pc_d     = out_pc_q;
        out_ppf_d    = out_ppf_q;
        out_instr_d  = out_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        count_d      = accept ? count_q + 32'd1 : count_q;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (accept) valid_d = 1'b0;
                if (imem_ack) begin
                    if (kill_q) begin
                        // response belongs to a pre-redirect address: drop it
                        kill_d = 1'b0;
                    end else if (slot_free) begin
                        valid_d     = 1'b1;
                        out_pc_d    = pc_q;
                        out_ppf_d   = pc_q + FOUR;
                        out_instr_d = imem_rdata;
                        pc_d        = pc_q + FOUR;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_q + FOUR;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    out_pc_d    = skid_pc_q;
                    out_ppf_d   = skid_pc_q + FOUR;
                    out_instr_d = skid_instr_q;
                    state_d     = ST_FETCH;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (redirect_valid && state_q != ST_RST) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            valid_d = 1'b0;
            state_d = ST_FETCH;
            // an unanswered request must stay on its original address until acked
            if (imem_req && !imem_ack) begin
                kill_d      = 1'b1;
                held_addr_d = imem_addr;
            end else begin
                kill_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RST;
            pc_q         <= RESET_PC;
            held_addr_q  <= RESET_PC;
            kill_q       <= 1'b0;
            valid_q      <= 1'b0;
            out_pc_q     <= '0;
            out_ppf_q    <= '0;
            out_instr_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            held_addr_q  <= held_addr_d;
            kill_q       <= kill_d;
            valid_q      <= valid_d;
            out_pc_q     <= out_pc_d;
            out_ppf_q    <= out_ppf_d;
            out_instr_q  <= out_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a variable-latency memory model returning ~addr.
module tb_fetch_controller;
    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_four;
    logic [31:0] if_instruction;
    logic [31:0] fetched_count;

    int tests;
    int fails;
    int lat;
    int wait_cnt;

    fetch_controller #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_pc_plus_four (if_pc_plus_four),
        .if_instruction  (if_instruction),
        .fetched_count   (fetched_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after lat cycles of continuous request; abandons on reset or dropped req.
    assign imem_ack   = imem_req && (wait_cnt == lat);
    assign imem_rdata = ~imem_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; lat = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_ppf",   if_pc_plus_four, 32'h0);
        check("rst_instr", if_instruction, 32'h0);
        check("rst_count", fetched_count, 32'd0);

        // zero-wait streaming
        tick(); rst = 1'b1;
        tick();
        check("a_req1",   {31'd0, imem_req}, 32'd1);
        check("a_valid0", {31'd0, if_valid}, 32'd0);
        check("a_addr0",  imem_addr, 32'h0);
        tick();
        check("a_valid1", {31'd0, if_valid}, 32'd1);
        check("a_pc0",    if_pc, 32'h0);
        check("a_ppf0",   if_pc_plus_four, 32'h4);
        check("a_ins0",   if_instruction, ~32'h0);
        check("a_cnt0",   fetched_count, 32'd0);
        tick();
        check("a_pc4",    if_pc, 32'h4);
        check("a_cnt1",   fetched_count, 32'd1);
        tick();
        check("a_pc8",    if_pc, 32'h8);
        check("a_cnt2",   fetched_count, 32'd2);
        if_ready = 1'b0;

        // decode stall: 0x8 held, 0xC parked in skid
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_hold_pc",  if_pc, 32'h8);
            check("b_hold_req", {31'd0, imem_req}, 32'd0);
            check("b_hold_cnt", fetched_count, 32'd2);
        end
        if_ready = 1'b1;
        tick();
        check("b_pcC",    if_pc, 32'hC);
        check("b_insC",   if_instruction, ~32'hC);
        check("b_cnt3",   fetched_count, 32'd3);
        check("b_addr10", imem_addr, 32'h10);
        tick();
        check("b_pc10",   if_pc, 32'h10);
        check("b_cnt4",   fetched_count, 32'd4);

        // two-cycle memory latency
        rst = 1'b0; lat = 2;
        #1 check("c_rst_cnt", fetched_count, 32'd0);
        tick(); rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                tick();
                check("c_wait_valid", {31'd0, if_valid}, 32'd0);
                check("c_wait_req",   {31'd0, imem_req}, 32'd1);
                check("c_wait_addr",  imem_addr, 32'(4 * i));
            end
            tick();
            check("c_valid", {31'd0, if_valid}, 32'd1);
            check("c_pc",    if_pc, 32'(4 * i));
        end
        check("c_cnt2", fetched_count, 32'd2);

        // redirect while 0x10 is outstanding with latency 3
        lat = 3;
        repeat (4) tick();
        check("d_pcC",   if_pc, 32'hC);
        check("d_addr",  imem_addr, 32'h10);
        tick();
        check("d_cnt4",  fetched_count, 32'd4);
        check("d_addr1", imem_addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); redirect_valid = 1'b0;
        check("d_kill_addr", imem_addr, 32'h10);
        check("d_kill_req",  {31'd0, imem_req}, 32'd1);
        check("d_flush",     {31'd0, if_valid}, 32'd0);
        tick();
        check("d_kill_addr2", imem_addr, 32'h10);
        tick();
        check("d_new_addr",   imem_addr, 32'h100);
        check("d_drop_valid", {31'd0, if_valid}, 32'd0);
        lat = 0;
        tick();
        check("d_pc100",  if_pc, 32'h100);
        check("d_ins100", if_instruction, ~32'h100);
        check("d_cnt4b",  fetched_count, 32'd4);

        // redirect to unaligned target coincident with ack and accept
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0;
        check("e_valid0", {31'd0, if_valid}, 32'd0);
        check("e_cnt5",   fetched_count, 32'd5);
        check("e_addr",   imem_addr, 32'h100);
        tick();
        check("e_pc",     if_pc, 32'h100);
        check("e_ppf",    if_pc_plus_four, 32'h104);

        // async reset while parked in HOLD
        if_ready = 1'b0;
        tick();
        check("f_hold_req", {31'd0, imem_req}, 32'd0);
        check("f_hold_pc",  if_pc, 32'h100);
        #2 rst = 1'b0;
        #1;
        check("f_valid", {31'd0, if_valid}, 32'd0);
        check("f_req",   {31'd0, imem_req}, 32'd0);
        check("f_addr",  imem_addr, 32'h0);
        check("f_pc",    if_pc, 32'h0);
        check("f_cnt",   fetched_count, 32'd0);
        tick(); rst = 1'b1; if_ready = 1'b1;
        tick();
        tick();
        check("f_re_pc0", if_pc, 32'h0);
        check("f_re_v",   {31'd0, if_valid}, 32'd1);
        tick();
        check("f_re_pc4", if_pc, 32'h4);
        check("f_re_cnt", fetched_count, 32'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); redirect_valid = 1'b0;
        check("g_cnt2", fetched_count, 32'd2);
        check("g_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("g_pc_top",  if_pc, 32'hFFFF_FFFC);
        check("g_ppf_top", if_pc_plus_four, 32'h0);
        tick();
        check("g_pc_wrap", if_pc, 32'h0);
        check("g_ppf4",    if_pc_plus_four, 32'h4);
        check("g_cnt3",    fetched_count, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the RISC-V core. Owns the PC register and drives a request/acknowledge instruction-memory port that tolerates variable latency. Delivers instructions to decode over a valid/ready handshake with a one-entry skid buffer, and applies branch/jump redirects from later stages. Replaces the free-running PC-plus-four loop so fetch can stall and flush.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
redirect_valid  input  1  take redirect_pc this cycle (branch/jump resolved)
redirect_pc  input  XLEN  target PC; bits [1:0] ignored (forced 0)
imem_req  output  1  memory request; held until imem_ack
imem_addr  output  XLEN  request address; stable while imem_req=1
imem_ack  input  1  response valid this cycle; may coincide with first req cycle
imem_rdata  input  XLEN  instruction word, valid when imem_ack=1
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts this cycle
if_pc  output  XLEN  PC of if_instruction
if_pc_plus_four  output  XLEN  if_pc + 4
if_instruction  output  XLEN  fetched instruction
fetched_count  output  32  instructions handed to decode

Behaviour:
- Reset (rst=0, asynchronous): pc_r=RESET_PC, state=RST, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_pc_plus_four=0, if_instruction=0, skid empty, kill=0, fetched_count=0.
- States: RST (req=0), FETCH (req=1), HOLD (req=0, skid full). RST -> FETCH on first clock edge after reset release; the earliest if_valid is 2 cycles after release with zero-wait memory.
- imem_addr = held_addr while kill=1, else pc_r. Once imem_req is asserted, it is never dropped before imem_ack, except on reset.
- Accept = if_valid & if_ready. "Slot free" = !if_valid | accept.
- FETCH, ack, slot free: load output regs (instruction=imem_rdata, pc=pc_r, pc_plus_four=pc_r+4), if_valid=1, pc_r+=4, stay FETCH. This gives a throughput of 1 instr/cycle with zero-wait memory.
- FETCH, ack, slot full and no accept: store response in skid, pc_r+=4, go HOLD.
- HOLD: when accept, skid moves to output regs (if_valid stays 1), skid empties, go FETCH. With no accept, stay HOLD and keep all values unchanged.
- FETCH without ack: hold req/addr; output updates only via accept (if_valid falls on accept).
- Redirect (highest priority, any state but RST):
  - pc_r = {redirect_pc[XLEN-1:2],2'b00}; if_valid=0; skid emptied; next state FETCH.
  - If req high and no ack this cycle: kill=1 and held_addr keeps the old address. The in-flight response is discarded on its ack, kill clears, and the next cycle requests the new pc_r.
  - If ack in the same cycle: the response is discarded and the next request uses the new pc_r.
  - A second redirect while kill=1 only updates pc_r.
- Accept coincident with redirect: the handshake counts (fetched_count increments); the output is then flushed.
- fetched_count += 1 on every accept; wraps 32'hFFFF_FFFF -> 0.
- PC arithmetic is modulo 2^XLEN; pc_r = 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-transaction: req drops immediately; the memory must abandon the request; any response is ignored.
- Outputs hold stable while if_valid=1 and if_ready=0.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory (ack=req), if_ready=1 -> if_valid rises 2 cycles after release; if_pc 0x0, 0x4, 0x8... on consecutive cycles; fetched_count matches accepts.
- Same setup, if_ready=0 for 3 cycles while if_pc=0x8 -> 0x8 held; imem_req low in HOLD with 0xC in skid; after release, delivers 0x8, 0xC, 0x10 with no drop or duplicate.
- Memory with 2-cycle ack latency -> imem_addr/imem_req stable until ack; one instruction every 3 cycles; pcs 0x0, 0x4, 0x8.
- Request to 0x10 outstanding (latency 3), redirect_pc=0x100 one cycle in -> 0x10 response discarded; next imem_addr=0x100; first if_pc after redirect is 0x100.
- redirect_pc=0x103 on a cycle where ack and accept also occur -> accept counted; response dropped; next if_pc=0x100 with if_pc_plus_four=0x104.
- Assert rst asynchronously mid-request while in HOLD -> outputs immediately return to reset values; after release, fetch restarts at RESET_PC.
